// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store byte-lane controller with valid/ack data memory handshake
module dmem_access_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [4:0]      lstype,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t          state, state_nxt;
  logic [4:0]      lst_q;
  logic [1:0]      off_q;
  logic [CW-1:0]   cnt;

  logic            is_b, is_h, is_w;
  logic            illegal, misal, bad_req, tmo;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wd_c;
  logic [15:0]     sel;
  logic [XLEN-1:0] ld_data;

  // lstype bit order: {lb/sb, lh/sh, lw/sw, lbu, lhu}; anything not one-hot is rejected
  always_comb begin
    is_b    = lstype[4] | lstype[1];
    is_h    = lstype[3] | lstype[0];
    is_w    = lstype[2];
    illegal = !$onehot(lstype) || (req_we && (lstype[1] || lstype[0]));
    misal   = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
    bad_req = illegal || misal;
    be_c    = 4'b1111;
    wd_c    = req_wdata;
    if (is_b) begin
      be_c = 4'b0001 << req_addr[1:0];
      wd_c = {4{req_wdata[7:0]}};
    end else if (is_h) begin
      be_c = 4'b0011 << req_addr[1:0];
      wd_c = {2{req_wdata[15:0]}};
    end
  end

  always_comb begin
    sel     = 16'(mem_rdata >> {off_q, 3'b000});
    ld_data = '0;
    if (lst_q[4])      ld_data = {{(XLEN-8){sel[7]}}, sel[7:0]};
    else if (lst_q[1]) ld_data = {{(XLEN-8){1'b0}}, sel[7:0]};
    else if (lst_q[3]) ld_data = {{(XLEN-16){sel[15]}}, sel[15:0]};
    else if (lst_q[0]) ld_data = {{(XLEN-16){1'b0}}, sel[15:0]};
    else if (lst_q[2]) ld_data = mem_rdata;
  end

  assign tmo   = (TIMEOUT != 0) && (cnt == TLAST);
  assign stall = req_valid && ((state == IDLE) || (state == WAIT));
  assign fault = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = bad_req ? ERR : WAIT;
      WAIT: begin
        if (mem_ack)  state_nxt = DONE;
        else if (tmo) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // memory-side registers; mem_we doubles as the load/store flag of the latched access
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      lst_q     <= '0;
      off_q     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !bad_req) begin
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= wd_c;
            off_q     <= req_addr[1:0];
            lst_q     <= lstype;
            cnt       <= '0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) rdata <= ld_data;
          end else begin
            cnt <= cnt + 1'b1;
            if (tmo) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end
          end
        end
        DONE:    rdata <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl with random memory latency
module tb_dmem_access_ctrl;

  localparam int TO = 16;
  localparam logic [4:0] LB = 5'b10000, LH = 5'b01000, LW = 5'b00100;
  localparam logic [4:0] LBU = 5'b00010, LHU = 5'b00001;

  logic        clk, rst, req_valid, req_we;
  logic [4:0]  lstype;
  logic [31:0] req_addr, req_wdata;
  logic        stall, fault, mem_req, mem_we, mem_ack;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  dmem_access_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .lstype(lstype),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rdata(rdata),
    .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic fault; logic [31:0] rdata; int stalls; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; int cnt; } mem_t;
  typedef struct { int lat; logic [31:0] word; } plan_t;

  resp_t resp_q[$];
  mem_t  mem_q[$];
  plan_t plan_q[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // reference model: access size, signedness and legality straight from the load/store rules
  function automatic void model(input logic we, input logic [4:0] lst, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] word,
                                output logic legal, output logic [3:0] be,
                                output logic [31:0] ewd, output logic [31:0] erd);
    int size, off;
    bit sgn;
    logic [31:0] v, mask;
    off = int'(addr % 4);
    size = 0; sgn = 0;
    case (lst)
      LB:  begin size = 1; sgn = 1; end
      LBU: begin size = 1; sgn = 0; end
      LH:  begin size = 2; sgn = 1; end
      LHU: begin size = 2; sgn = 0; end
      LW:  begin size = 4; sgn = 1; end
      default: size = 0;
    endcase
    legal = 1'b0;
    if (size != 0) legal = !(we && !sgn) && ((off % size) == 0);
    be = 4'(((1 << size) - 1) << off);
    if (size == 1)      ewd = {24'h0, wd[7:0]} * 32'h0101_0101;
    else if (size == 2) ewd = {16'h0, wd[15:0]} * 32'h0001_0001;
    else                ewd = wd;
    erd = 32'h0;
    if (!we && size != 0) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
      v = (word >> (8 * off)) & mask;
      if (sgn && size < 4 && v[8 * size - 1]) v = v | ~mask;
      erd = v;
    end
  endfunction

  task automatic run_txn(input logic we, input logic [4:0] lst, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] word, input int lat,
                         input logic legal, input logic [3:0] be,
                         input logic [31:0] ewd, input logic [31:0] erd);
    resp_t r;
    mem_t  m;
    plan_t p;
    int n;
    r.fault  = !legal || (lat == 0);
    r.rdata  = (r.fault || we) ? 32'h0 : erd;
    r.stalls = !legal ? 1 : ((lat == 0) ? 1 + TO : 1 + lat);
    resp_q.push_back(r);
    if (legal) begin
      m.addr = addr & ~32'h3; m.be = be; m.we = we; m.wdata = ewd;
      m.cnt = (lat == 0) ? TO : lat;
      mem_q.push_back(m);
      p.lat = lat; p.word = word;
      plan_q.push_back(p);
    end
    req_valid = 1'b1; req_we = we; lstype = lst; req_addr = addr; req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (stall && n >= 2) begin
        req_we = 1'($urandom); lstype = 5'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
    end while (stall && n < 100);
    if (stall) begin
      $display("FAIL txn_complete actual=stalled required=done t=%0t", $time);
      bad++; total++;
      finish_run();
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // memory responder: pops a latency plan per request; lat 0 never acks and then sends a stray ack
  int r_left, r_lat;
  logic r_active, r_prev;
  logic [31:0] r_word;
  initial begin
    r_active = 0; r_prev = 0; r_left = 0; r_lat = 1; r_word = 0;
    mem_ack = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (rst) begin
        r_active = 0;
      end else begin
        if (r_active && !mem_req) begin
          r_active = 0;
          if (r_lat == 0) mem_ack = 1'b1;
        end
        if (mem_req && !r_prev) begin
          if (plan_q.size() == 0) begin
            chk("plan_available", 32'(plan_q.size()), 32'd1);
            r_lat = 1; r_word = 0;
          end else begin
            plan_t p;
            p = plan_q.pop_front();
            r_lat = p.lat; r_word = p.word;
          end
          r_left = r_lat;
          r_active = 1;
        end
        if (r_active && r_lat > 0) begin
          if (r_left == 1) begin
            mem_ack = 1'b1; mem_rdata = r_word; r_active = 0;
          end else begin
            r_left--;
          end
        end else if (!r_active && !mem_ack && $urandom_range(0, 7) == 0) begin
          mem_ack = 1'b1;
        end
      end
      r_prev = mem_req;
    end
  end

  // monitor: completion is the cycle the core is released (req_valid high, stall low)
  int stall_cnt = 0, mcnt = 0;
  logic mprev = 0;
  mem_t cur;
  always @(negedge clk) begin
    if (req_valid && stall) begin
      stall_cnt++;
      chk("fault_while_stalled", {31'h0, fault}, 32'h0);
    end else if (req_valid && !stall && !rst) begin
      if (resp_q.size() == 0) begin
        chk("resp_expected", 32'h0, 32'h1);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        chk("resp_fault", {31'h0, fault}, {31'h0, r.fault});
        chk("resp_rdata", rdata, r.rdata);
        chk("resp_stall_cycles", 32'(stall_cnt), 32'(r.stalls));
      end
      stall_cnt = 0;
    end else begin
      stall_cnt = 0;
      chk("quiet_fault", {31'h0, fault}, 32'h0);
      chk("quiet_rdata", rdata, 32'h0);
    end

    if (mem_req && !mprev) begin
      if (mem_q.size() == 0) begin
        chk("mem_req_expected", 32'h0, 32'h1);
        cur.cnt = -1;
      end else begin
        cur = mem_q.pop_front();
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_be", {28'h0, mem_be}, {28'h0, cur.be});
        chk("mem_we", {31'h0, mem_we}, {31'h0, cur.we});
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        cur.addr = mem_addr; cur.be = mem_be; cur.wdata = mem_wdata;
      end
      mcnt = 1;
    end else if (mem_req && mprev) begin
      mcnt++;
      if (mem_addr !== cur.addr || mem_be !== cur.be || mem_wdata !== cur.wdata || mem_we !== cur.we)
        chk("mem_stable", 32'h0, 32'h1);
    end else if (!mem_req && mprev) begin
      chk("mem_req_cycles", 32'(mcnt), 32'(cur.cnt));
    end
    mprev = mem_req;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
    chk({tag, "_fault"}, {31'h0, fault}, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_be"}, {28'h0, mem_be}, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    bad++; total++;
    finish_run();
  end

  initial begin
    logic legal;
    logic [3:0] be;
    logic [31:0] ewd, erd, addr, wd, word;
    logic [4:0] lst;
    logic we;
    int lat, idx;
    plan_t p;
    mem_t m;

    rst = 1; req_valid = 0; req_we = 0; lstype = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 0;
    @(posedge clk); #1;

    run_txn(0, LB,  32'h103, 32'h0, 32'h80FF_1234, 2, 1, 4'b1000, 32'h0, 32'hFFFF_FF80);
    run_txn(0, LHU, 32'h202, 32'h0, 32'hBEEF_0000, 1, 1, 4'b1100, 32'h0, 32'h0000_BEEF);
    run_txn(0, LH,  32'h202, 32'h0, 32'hBEEF_0000, 1, 1, 4'b1100, 32'h0, 32'hFFFF_BEEF);
    run_txn(1, LB,  32'h301, 32'h1234_56AB, 32'h0, 1, 1, 4'b0010, 32'hABAB_ABAB, 32'h0);
    run_txn(1, LH,  32'h302, 32'h1234_56AB, 32'h0, 3, 1, 4'b1100, 32'h56AB_56AB, 32'h0);
    run_txn(0, LW,  32'h402, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0);
    run_txn(1, LH,  32'h401, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0);
    run_txn(0, 5'b0, 32'h100, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0);
    run_txn(1, LBU, 32'h100, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0);
    run_txn(0, LW,  32'h600, 32'h0, 32'h1111_2222, 0, 1, 4'b1111, 32'h0, 32'h0);
    @(posedge clk); #1;

    // reset in the second WAIT cycle: the access aborts silently
    m.addr = 32'h700; m.be = 4'b1111; m.we = 0; m.wdata = 0; m.cnt = 2;
    mem_q.push_back(m);
    p.lat = 50; p.word = 32'h0;
    plan_q.push_back(p);
    req_valid = 1; req_we = 0; lstype = LW; req_addr = 32'h700; req_wdata = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; req_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero("midrst");
    rst = 0;
    @(posedge clk); #1;
    run_txn(0, LW, 32'h500, 32'h0, 32'hCAFE_F00D, 2, 1, 4'b1111, 32'h0, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) begin
      idx  = $urandom_range(0, 5);
      lst  = (idx == 5) ? 5'b0 : 5'(5'b1 << idx);
      we   = 1'($urandom);
      addr = $urandom;
      wd   = $urandom;
      word = $urandom;
      lat  = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
      model(we, lst, addr, wd, word, legal, be, ewd, erd);
      run_txn(we, lst, addr, wd, word, lat, legal, be, ewd, erd);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("resp_q_drained", 32'(resp_q.size()), 32'h0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'h0);
    chk("plan_q_drained", 32'(plan_q.size()), 32'h0);
    finish_run();
  end

endmodule
